// File: rtl/bist_pkg.sv
// Shared types and polynomial constants for the per-scan BIST engine.
// Pattern LFSR and MISR both use x^16+x^14+x^13+x^11+1.
package bist_pkg;

  localparam int LFSR_W = 16;
  localparam logic [LFSR_W-1:0] LFSR_POLY = 16'h6801;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_CAPTURE,
    S_UNLOAD,
    S_COMPARE,
    S_DONE
  } bist_state_t;

  function automatic logic [LFSR_W-1:0] lfsr_step(
    input logic [LFSR_W-1:0] v,
    input logic              din
  );
    logic [LFSR_W-1:0] fb;
    fb = v[LFSR_W-1] ? LFSR_POLY : '0;
    return {v[LFSR_W-2:0], 1'b0} ^ fb
         ^ {{(LFSR_W-1){1'b0}}, din};
  endfunction

endpackage

// File: rtl/bist_scan_controller_if.sv
// Start/result handshake and CUT scan-chain bundle.
// master = BIST controller, slave = CUT side / BIST top.
interface bist_scan_controller_if;

  logic bist_start;
  logic scan_out;
  logic scan_en;
  logic scan_in;
  logic test_mode;
  logic busy;
  logic bist_end;
  logic pass_nfail;

  modport master (
    input  bist_start,
    input  scan_out,
    output scan_en,
    output scan_in,
    output test_mode,
    output busy,
    output bist_end,
    output pass_nfail
  );

  modport slave (
    output bist_start,
    output scan_out,
    input  scan_en,
    input  scan_in,
    input  test_mode,
    input  busy,
    input  bist_end,
    input  pass_nfail
  );

endinterface

// File: rtl/bist_lfsr16.sv
// 16-bit Galois shift register; din = 0 gives a PRPG, din = data a MISR.
// Reset and load both force the register to the seed input.
module bist_lfsr16
  import bist_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic [LFSR_W-1:0] seed,
  input  logic              en,
  input  logic              din,
  output logic [LFSR_W-1:0] q
);

  always_ff @(posedge clock) begin
    if (reset || load) begin
      q <= seed;
    end else if (en) begin
      q <= lfsr_step(q, din);
    end
  end

endmodule

// File: rtl/bist_scan_controller.sv
// Per-scan BIST sequencer: PRPG load, capture, MISR unload, golden compare.
// Outputs are registered from the next state so they align with run cycles.
module bist_scan_controller
  import bist_pkg::*;
#(
  parameter int unsigned      SCAN_LEN   = 8,
  parameter int unsigned      N_PATTERNS = 200,
  parameter logic [15:0]      SEED       = 16'hACE1,
  parameter logic [15:0]      GOLDEN_SIG = 16'h0000
) (
  input  logic                    clock,
  input  logic                    reset,
  bist_scan_controller_if.master  bus
);

  localparam int BW = $clog2(SCAN_LEN + 1);
  localparam int PW = $clog2(N_PATTERNS + 1);

  localparam logic [LFSR_W-1:0] SEED_EFF =
    (SEED == '0) ? 16'h0001 : SEED;
  localparam logic [BW-1:0] BIT_LAST = BW'(SCAN_LEN - 1);
  localparam logic [PW-1:0] PAT_LAST = PW'(N_PATTERNS);

  bist_state_t state_q, state_d;

  logic          start_q;
  logic          start;
  logic [BW-1:0] bit_q, bit_d;
  logic [PW-1:0] pat_q, pat_d;

  logic              init;
  logic              lfsr_en;
  logic              misr_en;
  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] misr_q;

  logic se_q;
  logic sh_q;
  logic busy_q;
  logic end_q;
  logic pass_q;

  assign start = bus.bist_start & ~start_q;

  bist_lfsr16 u_prpg (
    .clock (clock),
    .reset (reset),
    .load  (init),
    .seed  (SEED_EFF),
    .en    (lfsr_en),
    .din   (1'b0),
    .q     (lfsr_q)
  );

  bist_lfsr16 u_misr (
    .clock (clock),
    .reset (reset),
    .load  (init),
    .seed  ('0),
    .en    (misr_en),
    .din   (bus.scan_out),
    .q     (misr_q)
  );

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    pat_d   = pat_q;
    init    = 1'b0;
    lfsr_en = 1'b0;
    misr_en = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          init    = 1'b1;
          bit_d   = '0;
          pat_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        lfsr_en = 1'b1;
        // chain holds garbage until the first pattern is in
        misr_en = (pat_q != '0);
        if (bit_q == BIT_LAST) begin
          bit_d   = '0;
          state_d = S_CAPTURE;
        end else begin
          bit_d = bit_q + BW'(1);
        end
      end
      S_CAPTURE: begin
        pat_d   = pat_q + PW'(1);
        state_d = (pat_d == PAT_LAST) ? S_UNLOAD : S_SHIFT;
      end
      S_UNLOAD: begin
        misr_en = 1'b1;
        if (bit_q == BIT_LAST) begin
          bit_d   = '0;
          state_d = S_COMPARE;
        end else begin
          bit_d = bit_q + BW'(1);
        end
      end
      S_COMPARE: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      start_q <= 1'b0;
      bit_q   <= '0;
      pat_q   <= '0;
    end else begin
      state_q <= state_d;
      start_q <= bus.bist_start;
      bit_q   <= bit_d;
      pat_q   <= pat_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      se_q   <= 1'b0;
      sh_q   <= 1'b0;
      busy_q <= 1'b0;
      end_q  <= 1'b0;
      pass_q <= 1'b0;
    end else begin
      se_q   <= (state_d == S_SHIFT) || (state_d == S_UNLOAD);
      sh_q   <= (state_d == S_SHIFT);
      busy_q <= state_d inside {S_SHIFT, S_CAPTURE,
                                S_UNLOAD, S_COMPARE};
      end_q  <= (state_d == S_DONE);
      if (state_q == S_COMPARE) begin
        pass_q <= (misr_q == GOLDEN_SIG);
      end else if (state_d != S_DONE) begin
        pass_q <= 1'b0;
      end
    end
  end

  // both operands are flops, so scan_in only moves on clock edges
  assign bus.scan_in    = sh_q & lfsr_q[LFSR_W-1];
  assign bus.scan_en    = se_q;
  assign bus.test_mode  = busy_q;
  assign bus.busy       = busy_q;
  assign bus.bist_end   = end_q;
  assign bus.pass_nfail = pass_q;

endmodule

// File: tb/tb_bist_scan_controller.sv
// Directed bench: 4-flop loopback chain, 3 patterns, golden from a local model.
// Covers reset, timing, stuck-at, first-pattern mask, abort and restart.
module tb_bist_scan_controller;

  function automatic logic [15:0] ref_sig(input logic stuck);
    logic [15:0] l;
    logic [15:0] m;
    logic [3:0]  ch;
    logic        so;
    l  = 16'hACE1;
    m  = 16'h0000;
    ch = 4'h0;
    for (int p = 0; p <= 3; p++) begin
      for (int b = 0; b < 4; b++) begin
        so = stuck ? 1'b1 : ch[3];
        if (p != 0)
          m = {m[14:0], 1'b0} ^ (m[15] ? 16'h6801 : 16'h0)
            ^ {15'b0, so};
        if (p < 3) begin
          ch = {ch[2:0], l[15]};
          l  = {l[14:0], 1'b0} ^ (l[15] ? 16'h6801 : 16'h0);
        end else begin
          ch = {ch[2:0], 1'b0};
        end
      end
    end
    return m;
  endfunction

  localparam logic [15:0] GOLDEN = ref_sig(1'b0);
  localparam logic [15:0] STUCK  = ref_sig(1'b1);

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic rnd   = 1'b0;
  int   mode  = 0;
  logic [3:0] chain = 4'h0;

  int n_cmp = 0;
  int n_bad = 0;

  bist_scan_controller_if bus ();

  bist_scan_controller #(
    .SCAN_LEN   (4),
    .N_PATTERNS (3),
    .SEED       (16'hACE1),
    .GOLDEN_SIG (GOLDEN)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  always @(posedge clock)
    if (bus.scan_en) chain <= {chain[2:0], bus.scan_in};

  assign bus.scan_out = (mode == 1) ? 1'b1 :
                        (mode == 2) ? rnd  : chain[3];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] outs();
    return {bus.scan_en, bus.scan_in, bus.test_mode,
            bus.busy, bus.bist_end, bus.pass_nfail};
  endfunction

  // start edge was driven on the previous negedge
  task automatic do_run(input string tag,
                        input logic exp_pass,
                        input logic rand_win);
    logic [18:0] se;
    logic [3:0]  si;
    logic [20:0] bz;
    logic [20:0] tm;
    logic [20:0] be;
    for (int c = 0; c <= 20; c++) begin
      @(negedge clock);
      if (rand_win) begin
        if (c < 4) rnd = 1'($urandom);
        else mode = 0;
      end
      if (c < 19) se[c] = bus.scan_en;
      if (c < 4) si[c] = bus.scan_in;
      bz[c] = bus.busy;
      tm[c] = bus.test_mode;
      be[c] = bus.bist_end;
      if (c == 0)
        chk({tag, ".clr"},
            {30'b0, bus.bist_end, bus.pass_nfail}, 32'h0);
    end
    chk({tag, ".scan_en"}, 32'(se), 32'(19'b1111011110111101111));
    chk({tag, ".scan_in"}, 32'(si), 32'(4'b1001));
    chk({tag, ".busy"}, 32'(bz), 32'(21'h0FFFFF));
    chk({tag, ".test_mode"}, 32'(tm), 32'(21'h0FFFFF));
    chk({tag, ".bist_end"}, 32'(be), 32'(21'h100000));
    chk({tag, ".pass"}, 32'(bus.pass_nfail), 32'(exp_pass));
  endtask

  initial begin
    bus.bist_start = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk("reset.idle", 32'(outs()), 32'h0);
    end

    @(negedge clock);
    bus.bist_start = 1'b1;
    do_run("loop", 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk("hold.norestart", 32'(outs()), 32'(6'b000011));
    end

    @(negedge clock);
    bus.bist_start = 1'b0;
    @(negedge clock);
    bus.bist_start = 1'b1;
    do_run("rerun", 1'b1, 1'b0);

    @(negedge clock);
    bus.bist_start = 1'b0;
    mode = 1;
    @(negedge clock);
    bus.bist_start = 1'b1;
    do_run("stuck1", STUCK == GOLDEN, 1'b0);
    chk("stuck1.sigdiff", 32'(STUCK != GOLDEN), 32'h1);

    @(negedge clock);
    bus.bist_start = 1'b0;
    mode = 2;
    @(negedge clock);
    bus.bist_start = 1'b1;
    do_run("mask", 1'b1, 1'b0 == 1'b1 ? 1'b0 : 1'b1);

    @(negedge clock);
    bus.bist_start = 1'b0;
    @(negedge clock);
    bus.bist_start = 1'b1;
    for (int c = 0; c <= 7; c++) @(negedge clock);
    chk("abort.busy", 32'(bus.busy), 32'h1);
    reset = 1'b1;
    bus.bist_start = 1'b0;
    @(negedge clock);
    chk("abort.outs", 32'(outs()), 32'h0);
    reset = 1'b0;
    @(negedge clock);
    bus.bist_start = 1'b1;
    do_run("post_abort", 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
